// File: rtl/vend_cmd_sched.sv
// Panel command scheduler: sync, edge-detect, latch, issue one-hot commands.
// Optional debounce filter: define VEND_SCHED_DEBOUNCE_EN.
module vend_cmd_sched #(
  parameter int GAP_CYCLES = 2,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] btn_in,
  input  logic       core_busy,
  output logic [6:0] cmd_out,
  output logic       cmd_valid,
  output logic [6:0] pending,
  output logic       drop,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    HOLD
  } state_t;

  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);
  localparam logic [6:0] PROD_MASK = 7'b0111000;

  state_t     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic [6:0] cmd_d;
  logic [6:0] grant;
  logic [6:0] pick;
  logic [6:0] clr;
  logic [6:0] sync1_q, sync2_q;
  logic [6:0] lvl, prev_q, rise;
  logic [6:0] pend_d;
  logic       drop_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef VEND_SCHED_DEBOUNCE_EN
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [6:0] deb_q;
  logic [7:0] deb_cnt_q [7];

  // Level follows the input only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int i = 0; i < 7; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign lvl = deb_q;
`else
  logic unused_deb;
  assign unused_deb = ^8'(DEB_CYCLES);
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= lvl;
  end

  assign rise = lvl & ~prev_q;

  // Cancel outranks the coins, coins outrank the products
  always_comb begin
    pick = '0;
    priority case (1'b1)
      pending[6]: pick = 7'b1000000;
      pending[0]: pick = 7'b0000001;
      pending[1]: pick = 7'b0000010;
      pending[2]: pick = 7'b0000100;
      pending[3]: pick = 7'b0001000;
      pending[4]: pick = 7'b0010000;
      pending[5]: pick = 7'b0100000;
      default:    pick = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    cmd_d   = '0;
    grant   = '0;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (core_busy) begin
          state_d = HOLD;
        end else if (|pending) begin
          grant   = pick;
          cmd_d   = pick;
          clr     = pick | (pick[6] ? PROD_MASK : 7'b0);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = GAP;
        gap_d   = GAP_LD;
      end
      GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) state_d = IDLE;
      end
      HOLD: begin
        if (!core_busy) state_d = IDLE;
      end
    endcase
  end

  // A new press on a bit being cleared survives: set wins
  assign pend_d   = (pending & ~clr) | rise;
  assign drop_now = |(rise & pending & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      cmd_out  <= '0;
      pending  <= '0;
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cmd_out <= cmd_d;
      pending <= pend_d;
      drop    <= drop_now;
      if (drop_now && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign cmd_valid = |cmd_out;

endmodule

// File: tb/tb_vend_cmd_sched.sv
// Directed bench for vend_cmd_sched: vector table plus corner sequences.
module tb_vend_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] btn_in = '0;
  logic       core_busy = 1'b0;
  logic [6:0] cmd_out;
  logic       cmd_valid;
  logic [6:0] pending;
  logic       drop;
  logic [7:0] drop_cnt;

  int nchk = 0;
  int nerr = 0;

`ifdef VEND_SCHED_DEBOUNCE_EN
  localparam int PW = 6;
`else
  localparam int PW = 1;
`endif

  vend_cmd_sched #(
    .GAP_CYCLES(2),
    .DEB_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .core_busy(core_busy),
    .cmd_out(cmd_out),
    .cmd_valid(cmd_valid),
    .pending(pending),
    .drop(drop),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] btn;
    logic       busy;
    logic [6:0] cmd;
    logic [6:0] pend;
    logic       drp;
    logic [7:0] dcnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [6:0] b, input logic bz,
                     input logic [6:0] c, input logic [6:0] p,
                     input logic d, input logic [7:0] n);
    vec_t v;
    v.btn = b; v.busy = bz; v.cmd = c;
    v.pend = p; v.drp = d; v.dcnt = n;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int ncmd;
  int ndrop;
  logic [6:0] last_cmd;
  bit got;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (cmd_valid) begin
        ncmd++;
        last_cmd = cmd_out;
      end
      if (drop) ndrop++;
    end
  endtask

  initial begin
    // money_10 held 5 cycles
    add(7'h02, 0, 7'h00, 7'h00, 0, 0);
    add(7'h02, 0, 7'h00, 7'h00, 0, 0);
    add(7'h02, 0, 7'h00, 7'h02, 0, 0);
    add(7'h02, 0, 7'h02, 7'h00, 0, 0);
    add(7'h02, 0, 7'h00, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    // money_5 and tea together
    add(7'h09, 0, 7'h00, 7'h00, 0, 0);
    add(7'h09, 0, 7'h00, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h09, 0, 0);
    add(7'h00, 0, 7'h01, 7'h08, 0, 0);
    add(7'h00, 0, 7'h00, 7'h08, 0, 0);
    add(7'h00, 0, 7'h00, 7'h08, 0, 0);
    add(7'h00, 0, 7'h00, 7'h08, 0, 0);
    add(7'h00, 0, 7'h08, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    // busy: tea then cancel
    add(7'h08, 1, 7'h00, 7'h00, 0, 0);
    add(7'h08, 1, 7'h00, 7'h00, 0, 0);
    add(7'h40, 1, 7'h00, 7'h08, 0, 0);
    add(7'h40, 1, 7'h00, 7'h08, 0, 0);
    add(7'h00, 1, 7'h00, 7'h48, 0, 0);
    add(7'h00, 1, 7'h00, 7'h48, 0, 0);
    add(7'h00, 0, 7'h00, 7'h48, 0, 0);
    add(7'h00, 0, 7'h40, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    add(7'h00, 0, 7'h00, 7'h00, 0, 0);
    // busy: money_50 twice
    add(7'h04, 1, 7'h00, 7'h00, 0, 0);
    add(7'h00, 1, 7'h00, 7'h00, 0, 0);
    add(7'h00, 1, 7'h00, 7'h04, 0, 0);
    add(7'h04, 1, 7'h00, 7'h04, 0, 0);
    add(7'h04, 1, 7'h00, 7'h04, 0, 0);
    add(7'h00, 1, 7'h00, 7'h04, 1, 1);
    add(7'h00, 1, 7'h00, 7'h04, 0, 1);
    add(7'h00, 0, 7'h00, 7'h04, 0, 1);
    add(7'h00, 0, 7'h04, 7'h00, 0, 1);
    add(7'h00, 0, 7'h00, 7'h00, 0, 1);
    add(7'h00, 0, 7'h00, 7'h00, 0, 1);
    add(7'h00, 0, 7'h00, 7'h00, 0, 1);
    add(7'h00, 0, 7'h00, 7'h00, 0, 1);

    #12;
    chk("rst cmd_out", 32'(cmd_out), 0);
    chk("rst cmd_valid", 32'(cmd_valid), 0);
    chk("rst pending", 32'(pending), 0);
    chk("rst drop", 32'(drop), 0);
    chk("rst drop_cnt", 32'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step(); step();

`ifndef VEND_SCHED_DEBOUNCE_EN
    foreach (tv[i]) begin
      btn_in    = tv[i].btn;
      core_busy = tv[i].busy;
      step();
      chk($sformatf("row%0d cmd", i), 32'(cmd_out), 32'(tv[i].cmd));
      chk($sformatf("row%0d valid", i), 32'(cmd_valid),
          32'(tv[i].cmd != 0));
      chk($sformatf("row%0d pend", i), 32'(pending), 32'(tv[i].pend));
      chk($sformatf("row%0d drop", i), 32'(drop), 32'(tv[i].drp));
      chk($sformatf("row%0d dcnt", i), 32'(drop_cnt), 32'(tv[i].dcnt));
    end
`endif

    // Saturating discard counter under busy
    core_busy = 1'b1;
    ncmd = 0; ndrop = 0;
    run(3);
    for (int p = 0; p < 301; p++) begin
      btn_in = 7'h01;
      run(PW);
      btn_in = 7'h00;
      run(PW);
    end
    run(12);
    chk("sat drop pulses", 32'(ndrop), 300);
    chk("sat drop_cnt", 32'(drop_cnt), 255);
    chk("sat pending", 32'(pending), 32'h01);
    chk("sat no cmd busy", 32'(ncmd), 0);
    core_busy = 1'b0;
    last_cmd = '0;
    run(20);
    chk("sat cmd count", 32'(ncmd), 1);
    chk("sat cmd value", 32'(last_cmd), 32'h01);

    // Async reset in GAP with tea+coke pending
    btn_in = 7'h19;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      step();
      if (cmd_valid) got = 1'b1;
    end
    chk("rg cmd seen", 32'(got), 1);
    chk("rg cmd first", 32'(cmd_out), 32'h01);
    chk("rg pend issue", 32'(pending), 32'h18);
    btn_in = 7'h00;
    step();
    chk("rg gap cmd", 32'(cmd_out), 0);
    chk("rg gap pend", 32'(pending), 32'h18);
    #2 rst_n = 1'b0;
    #1;
    chk("rg cmd_out", 32'(cmd_out), 0);
    chk("rg cmd_valid", 32'(cmd_valid), 0);
    chk("rg pending", 32'(pending), 0);
    chk("rg drop_cnt", 32'(drop_cnt), 0);
    #2 rst_n = 1'b1;
    ncmd = 0;
    run(20);
    chk("rg no cmd after", 32'(ncmd), 0);
    chk("rg pend after", 32'(pending), 0);

`ifdef VEND_SCHED_DEBOUNCE_EN
    ncmd = 0;
    btn_in = 7'h08;
    run(3);
    btn_in = 7'h00;
    run(20);
    chk("deb glitch", 32'(ncmd), 0);
    last_cmd = '0;
    btn_in = 7'h08;
    run(10);
    btn_in = 7'h00;
    run(30);
    chk("deb press count", 32'(ncmd), 1);
    chk("deb press value", 32'(last_cmd), 32'h08);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/vend_cmd_sched.md
# vend_cmd_sched

Command scheduler for the vending-machine core. Takes the raw panel inputs (three coin slots, three product buttons, cancel), synchronises them and latches each press as a pending request. It issues at most one single-cycle, one-hot command at a time to the vending core, and holds off while the core reports it is busy returning change. It sits between the board pushbuttons and the vending core, so the core never sees simultaneous or overlapping inputs.

## Interface
- GAP_CYCLES, 2: idle cycles forced after every issued command; legal range 1..15.
- DEB_CYCLES, 4: stable-sample count for the debounce filter; used only when the debounce feature is compiled in; legal range 2..255.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- btn_in  in  7  raw, asynchronous, level-high inputs; bit0 money_5, bit1 money_10, bit2 money_50, bit3 tea, bit4 coke, bit5 sprite, bit6 cancel.
- core_busy  in  1  high while the core is returning change; the core ignores commands while high.
- cmd_out  out  7  one-hot command using the btn_in bit order; nonzero for exactly one cycle per command.
- cmd_valid  out  1  high exactly when cmd_out is nonzero.
- pending  out  7  registered pending-request bits.
- drop  out  1  one-cycle pulse when a press is discarded.
- drop_cnt  out  8  discarded-press count; saturates at 255.

## Operation
- Input path: 2-flop synchroniser per bit, then the optional debounce filter, then a registered previous-level flop. Rising edge = current high and previous low.
- Pending set: a rising edge on bit i sets pending[i].
- Drop: if a rising edge arrives while pending[i] is already 1 and bit i is not being granted on that edge, the press is discarded. drop pulses, drop_cnt increments and saturates at 255.
- Grant priority is fixed: bit6 (cancel), then bit0, bit1, bit2, bit3, bit4, bit5.
- FSM states: IDLE, ISSUE, GAP, HOLD.
  - IDLE: if core_busy is 1, go to HOLD. Otherwise, if pending is nonzero, register the one-hot grant into cmd_out, clear that pending bit, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: cmd_out and cmd_valid are asserted for this single cycle; then go to GAP with the gap counter set to GAP_CYCLES.
  - GAP: cmd_out is 0; decrement the counter; when it reaches 1, go to IDLE.
  - HOLD: cmd_out is 0; return to IDLE on the first cycle core_busy is sampled 0.
- Cancel grant: on the edge that grants cancel, pending[5:3] are also cleared. Coin bits are kept.
- Simultaneous set and clear of the same pending bit on one edge: set wins, so the new press is kept pending.
- Presses accumulate in pending during GAP and HOLD.
- A level held high through reset deassertion counts as one press, because the previous-level flop resets to 0.

## Timing
- Reset values: state IDLE; pending, cmd_out, drop_cnt, and all synchroniser, filter and gap registers are 0; cmd_valid and drop are 0. Reset applies immediately on rst_n falling.
- Latency without debounce: btn_in first sampled high at edge k, pending set at edge k+2, cmd_out asserted after edge k+3. This assumes IDLE, core_busy=0 and no higher-priority pending bit.
- Minimum spacing between consecutive command pulses: GAP_CYCLES+2 cycles (ISSUE, GAP_CYCLES cycles of GAP, one IDLE cycle).
- core_busy is sampled only in IDLE and HOLD. If it rises during ISSUE or GAP, it takes effect on the next IDLE cycle.
- drop and the drop_cnt update occur on the same edge that pending would have been set.

## Configuration
- VEND_SCHED_DEBOUNCE_EN defined: a per-bit filter sits after the synchroniser. Its output level changes only after the synchronised input has held a new value for DEB_CYCLES consecutive cycles, which adds DEB_CYCLES cycles to the latency. Pulses shorter than DEB_CYCLES produce no press.
- Not defined: the synchroniser output feeds edge detection directly, DEB_CYCLES is unused, and no filter registers exist.

## Test plan
All scenarios use GAP_CYCLES=2 and no debounce unless noted.
- money_10 held high 5 cycles, core_busy=0 -> cmd_out=7'b0000010 for one cycle, 3 cycles after the first sampling edge; cmd_valid coincident; pending returns to 0.
- money_5 and tea rise on the same edge -> 7'b0000001 first, then 7'b0001000 exactly 4 cycles later.
- core_busy=1, tea pressed, then cancel pressed; core_busy then drops -> only 7'b1000000 is issued, tea is never issued, pending=0.
- core_busy=1, money_50 pressed twice -> the second press pulses drop and gives drop_cnt=1; after busy drops, exactly one 7'b0000100 is issued.
- pending=7'h18 in GAP, rst_n pulsed low -> all outputs 0 immediately; no command after release with btn_in=0.
- 300 discarded presses -> drop_cnt stops at 255. With debounce defined and DEB_CYCLES=4, a 3-cycle glitch -> no command; a 10-cycle press -> one command.
